// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: MODE encodings.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
// USR_ROTATE_EN adds the ROT signal.
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SI_L;
  logic             SI_R;
`ifdef USR_ROTATE_EN
  logic             ROT;
`endif
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             SO_L;
  logic             SO_R;

  modport master (
`ifdef USR_ROTATE_EN
    output ROT,
`endif
    output EN, MODE, D, SI_L, SI_R,
    input  Q, Q_bar, SO_L, SO_R
  );

  modport slave (
`ifdef USR_ROTATE_EN
    input  ROT,
`endif
    input  EN, MODE, D, SI_L, SI_R,
    output Q, Q_bar, SO_L, SO_R
  );
endinterface

// File: rtl/dff_cell.sv
// One-bit D flip-flop, asynchronous active-low reset to RST_VAL, with complement output.
module dff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic D,
  output logic Q,
  output logic Q_bar
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Q <= RST_VAL;
    end else begin
      Q <= D;
    end
  end

  assign Q_bar = ~Q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: hold / shift-left / shift-right / parallel load with enable.
// Define USR_ROTATE_EN to make the shift modes rotate when ROT=1.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic              CLK,
  input logic              RSTn,
  univ_shift_reg_if.slave  bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             shl_in;
  logic             shr_in;

  // Bits entering at each end; rotate feeds the opposite end back in.
  always_comb begin
    shl_in = bus.SI_L;
    shr_in = bus.SI_R;
`ifdef USR_ROTATE_EN
    if (bus.ROT) begin
      shl_in = q[WIDTH-1];
      shr_in = q[0];
    end
`endif
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    logic shl_src;
    logic shr_src;
    logic d_bit;

    if (i == 0) begin : g_lsb
      assign shl_src = shl_in;
    end else begin : g_shl
      assign shl_src = q[i-1];
    end

    if (i == int'(WIDTH) - 1) begin : g_msb
      assign shr_src = shr_in;
    end else begin : g_shr
      assign shr_src = q[i+1];
    end

    always_comb begin
      d_bit = q[i];
      if (bus.EN) begin
        unique case (usr_mode_e'(bus.MODE))
          MODE_HOLD: d_bit = q[i];
          MODE_SHL:  d_bit = shl_src;
          MODE_SHR:  d_bit = shr_src;
          MODE_LOAD: d_bit = bus.D[i];
        endcase
      end
    end

    dff_cell #(
      .RST_VAL(RST_VAL[i])
    ) u_cell (
      .CLK  (CLK),
      .RSTn (RSTn),
      .D    (d_bit),
      .Q    (q[i]),
      .Q_bar(q_bar[i])
    );
  end

  assign bus.Q     = q;
  assign bus.Q_bar = q_bar;
  assign bus.SO_L  = q[WIDTH-1];
  assign bus.SO_R  = q[0];

  // An unknown MODE while enabled would corrupt the register silently.
  mode_known_a : assert property (@(posedge CLK) disable iff (!RSTn)
    bus.EN |-> !$isunknown(bus.MODE));

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and random checks of univ_shift_reg (WIDTH=8, RST_VAL=8'hA5).
module tb_univ_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam logic [7:0]  RV    = 8'hA5;

  logic CLK;
  logic RSTn;
  int   checks;
  int   errors;

  univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

  univ_shift_reg #(
    .WIDTH  (WIDTH),
    .RST_VAL(RV)
  ) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, bus.Q}, {24'd0, exp});
    check({tag, "_qbar"}, {24'd0, bus.Q_bar}, {24'd0, ~exp});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] q, input logic en,
                                            input logic [1:0] mode, input logic [7:0] d,
                                            input logic sil, input logic sir, input logic rot);
    logic [7:0] n;
    n = q;
    if (en) begin
      case (mode)
        2'b01:   n = {q[6:0], rot ? q[7] : sil};
        2'b10:   n = {rot ? q[0] : sir, q[7:1]};
        2'b11:   n = d;
        default: n = q;
      endcase
    end
    return n;
  endfunction

  task automatic load(input logic [7:0] v);
    bus.EN   = 1'b1;
    bus.MODE = 2'b11;
    bus.D    = v;
    tick();
  endtask

  initial begin
    logic [7:0] exp;
    logic       rot;
    checks   = 0;
    errors   = 0;
    CLK      = 1'b0;
    RSTn     = 1'b1;
    bus.EN   = 1'b0;
    bus.MODE = 2'b00;
    bus.D    = 8'h00;
    bus.SI_L = 1'b0;
    bus.SI_R = 1'b0;
    rot      = 1'b0;
`ifdef USR_ROTATE_EN
    bus.ROT  = 1'b0;
`endif

    // Asynchronous reset between clock edges
    #2 RSTn = 1'b0;
    #1;
    check_q("rst_async", 8'hA5);
    check("rst_so_l", {31'd0, bus.SO_L}, 32'd1);
    check("rst_so_r", {31'd0, bus.SO_R}, 32'd1);

    bus.EN   = 1'b1;
    bus.MODE = 2'b11;
    bus.D    = 8'hFF;
    repeat (10) tick();
    check_q("rst_held", 8'hA5);

    RSTn  = 1'b1;
    bus.D = 8'h3C;
    tick();
    check_q("load_3c", 8'h3C);

    bus.EN = 1'b0;
    bus.D  = 8'hFF;
    repeat (5) tick();
    check_q("en_hold", 8'h3C);

    // Shift left
    load(8'h81);
    check_q("load_81", 8'h81);
    bus.MODE = 2'b01;
    bus.SI_L = 1'b1;
    tick();
    check_q("shl_1", 8'h03);
    check("shl_so_l", {31'd0, bus.SO_L}, 32'd0);
    bus.SI_L = 1'b0;
    repeat (2) tick();
    check_q("shl_3", 8'h0C);

    // Shift right
    load(8'h81);
    bus.MODE = 2'b10;
    bus.SI_R = 1'b0;
    tick();
    check_q("shr_1", 8'h40);
    check("shr_so_r", {31'd0, bus.SO_R}, 32'd0);
    bus.SI_R = 1'b1;
    tick();
    check_q("shr_2", 8'hA0);

    bus.MODE = 2'b00;
    tick();
    check_q("mode_hold", 8'hA0);

    // Reset dropped in the middle of a left-shift run
    bus.MODE = 2'b01;
    bus.SI_L = 1'b1;
    tick();
    check_q("shl_pre_rst", 8'h41);
    #2 RSTn = 1'b0;
    #1;
    check_q("rst_mid", 8'hA5);
    #1 RSTn = 1'b1;
    #1;
    check_q("rst_release_no_edge", 8'hA5);
    tick();
    check_q("shl_after_rst", 8'h4B);

`ifdef USR_ROTATE_EN
    bus.ROT  = 1'b1;
    bus.SI_L = 1'b0;
    bus.SI_R = 1'b0;
    load(8'h81);
    bus.MODE = 2'b01;
    tick();
    check_q("rot_left", 8'h03);
    load(8'h81);
    bus.MODE = 2'b10;
    tick();
    check_q("rot_right", 8'hC0);
    bus.ROT = 1'b0;
`endif

    // Random soak against the model, sampled at negedge
    exp = bus.Q;
    for (int n = 0; n < 400; n++) begin
      RSTn     = ($urandom_range(0, 15) != 0);
      bus.EN   = 1'($urandom_range(0, 1));
      bus.MODE = 2'($urandom_range(0, 3));
      bus.D    = 8'($urandom);
      bus.SI_L = 1'($urandom_range(0, 1));
      bus.SI_R = 1'($urandom_range(0, 1));
`ifdef USR_ROTATE_EN
      rot      = 1'($urandom_range(0, 1));
      bus.ROT  = rot;
`endif
      if (!RSTn) exp = RV;
      @(negedge CLK);
      check_q("soak", exp);
      check("soak_so_l", {31'd0, bus.SO_L}, {31'd0, exp[7]});
      check("soak_so_r", {31'd0, bus.SO_R}, {31'd0, exp[0]});
      @(posedge CLK);
      if (RSTn) exp = model_next(exp, bus.EN, bus.MODE, bus.D, bus.SI_L, bus.SI_R, rot);
      #1;
    end
    @(negedge CLK);
    check_q("soak_final", exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
